// File: rtl/exec_dispatch_pkg.sv
// exec_dispatch_pkg: functional-unit indices and the decode-side unit selector shared by the execute stage.
package exec_dispatch_pkg;
  typedef logic [2:0] exec_unit_t;
  localparam exec_unit_t EXEC_UNIT_MISC  = 3'd0;
  localparam exec_unit_t EXEC_UNIT_ALU   = 3'd1;
  localparam exec_unit_t EXEC_UNIT_MEM   = 3'd2;
  localparam exec_unit_t EXEC_UNIT_PCREL = 3'd3;
  localparam exec_unit_t EXEC_UNIT_CSR   = 3'd4;
  // SYSTEM with funct3 == 0 is ecall/ebreak, which the misc unit traps.
  function automatic exec_unit_t unit_of(input logic [6:0] op, input logic [2:0] funct3);
    return (op == 7'b0110011 || op == 7'b0010011) ? EXEC_UNIT_ALU :
           (op == 7'b0000011 || op == 7'b0100011) ? EXEC_UNIT_MEM :
           (op == 7'b0010111 || op == 7'b0110111 || op == 7'b1101111 || op == 7'b1100111) ? EXEC_UNIT_PCREL :
           (op == 7'b1110011 && funct3 != 3'd0) ? EXEC_UNIT_CSR : EXEC_UNIT_MISC;
  endfunction
endpackage

// File: rtl/exec_dispatch_if.sv
// exec_dispatch_if: issue, unit and in-order result signals of the execute dispatcher.
interface exec_dispatch_if #(
  parameter int NUM_UNITS = 5,
  parameter int DATA_W = 128,
  parameter int RES_W = 96
);
  logic                          in_valid;
  logic                          in_ready;
  logic [$clog2(NUM_UNITS)-1:0]  in_unit;
  logic [DATA_W-1:0]             in_data;
  logic [NUM_UNITS-1:0]          unit_valid;
  logic [NUM_UNITS-1:0]          unit_ready;
  logic [DATA_W-1:0]             unit_data;
  logic [NUM_UNITS-1:0]          unit_res_valid;
  logic [NUM_UNITS-1:0]          unit_res_ready;
  logic [NUM_UNITS*RES_W-1:0]    unit_res_data;
  logic                          out_valid;
  logic                          out_ready;
  logic [RES_W-1:0]              out_data;
  logic                          busy;
  modport master (
    output in_valid, in_unit, in_data, unit_ready, unit_res_valid, unit_res_data, out_ready,
    input  in_ready, unit_valid, unit_data, unit_res_ready, out_valid, out_data, busy
  );
  modport slave (
    input  in_valid, in_unit, in_data, unit_ready, unit_res_valid, unit_res_data, out_ready,
    output in_ready, unit_valid, unit_data, unit_res_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/exec_id_fifo.sv
// exec_id_fifo: DEPTH x W FIFO with count/full/empty; push while full and pop while empty are ignored.
module exec_id_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] head, tail;
  logic wr, rd;
  assign wr = push && !full;
  assign rd = pop && !empty;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign dout = mem[head];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      if (wr) tail <= tail + 1'b1;
      if (rd) head <= head + 1'b1;
      count <= count + {{AW{1'b0}}, wr} - {{AW{1'b0}}, rd};
    end
  always_ff @(posedge clk)
    if (wr) mem[tail] <= din;
endmodule

// File: rtl/exec_dispatch.sv
// exec_dispatch: issues to NUM_UNITS units and returns results in program order; EXEC_DISPATCH_OUT_REG_EN adds a 2-entry output skid buffer.
module exec_dispatch
  import exec_dispatch_pkg::*;
#(
  parameter int NUM_UNITS = 5,
  parameter int DATA_W = 128,
  parameter int RES_W = 96,
  parameter int DEPTH = 4
) (
  input logic            clk,
  input logic            rst,
  exec_dispatch_if.slave bus
);
  localparam int UW = $clog2(NUM_UNITS);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [UW:0] NU = (UW+1)'(NUM_UNITS);
  logic [UW-1:0] u, h;
  logic [CW-1:0] q_count;
  logic q_full, q_empty, push, pop;
  logic [RES_W-1:0] res [NUM_UNITS];
  genvar i;
  for (i = 0; i < NUM_UNITS; i++) begin : g_res
    assign res[i] = bus.unit_res_data[i*RES_W +: RES_W];
  end
  assign bus.unit_data = bus.in_data;
  always_comb begin
    u = ({1'b0, bus.in_unit} < NU) ? bus.in_unit : UW'(EXEC_UNIT_MISC);
    bus.in_ready = !q_full && bus.unit_ready[u];
    bus.unit_valid = (bus.in_valid && !q_full) ? NUM_UNITS'(1) << u : '0;
    push = bus.in_valid && bus.in_ready;
    bus.busy = q_count != '0;
  end
  exec_id_fifo #(.DEPTH(DEPTH), .W(UW)) u_queue (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .din(u), .dout(h),
    .count(q_count), .full(q_full), .empty(q_empty)
  );
`ifdef EXEC_DISPATCH_OUT_REG_EN
  logic take, sk_full, sk_empty;
  logic [1:0] sk_count_unused;
  // The head unit drains into the skid buffer, so out_ready never reaches the units.
  always_comb begin
    take = !q_empty && bus.unit_res_valid[h] && !sk_full;
    bus.unit_res_ready = (!q_empty && !sk_full) ? NUM_UNITS'(1) << h : '0;
    pop = take;
    bus.out_valid = !sk_empty;
  end
  exec_id_fifo #(.DEPTH(2), .W(RES_W)) u_skid (
    .clk(clk), .rst(rst), .push(take), .pop(bus.out_ready), .din(res[h]), .dout(bus.out_data),
    .count(sk_count_unused), .full(sk_full), .empty(sk_empty)
  );
`else
  always_comb begin
    bus.out_valid = !q_empty && bus.unit_res_valid[h];
    bus.out_data = res[h];
    bus.unit_res_ready = (!q_empty && bus.out_ready) ? NUM_UNITS'(1) << h : '0;
    pop = bus.out_valid && bus.out_ready;
  end
`endif
endmodule

// File: tb/tb_exec_dispatch.sv
// tb_exec_dispatch: directed checks of issue, in-order completion, full queue, back-pressure and async reset.
module tb_exec_dispatch;
  import exec_dispatch_pkg::*;
  logic clk = 1'b0;
  logic rst;
  int total = 0;
  int bad = 0;
  int ic [5];
  int rc [5];
  int issued, got;
  always #5 clk = ~clk;
  exec_dispatch_if #(.NUM_UNITS(5), .DATA_W(128), .RES_W(96)) bus ();
  exec_dispatch #(.NUM_UNITS(5), .DATA_W(128), .RES_W(96), .DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  task automatic chk(input string t, input logic [127:0] o, input logic [127:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", t, o, e);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic set_res(input int n, input logic [95:0] d);
    bus.unit_res_data[n*96 +: 96] = d;
    bus.unit_res_valid[n] = 1'b1;
  endtask
  initial begin
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_unit = '0;
    bus.in_data = 128'hDEAD_BEEF;
    bus.unit_ready = 5'b11111;
    bus.unit_res_valid = '0;
    bus.unit_res_data = '0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_ov", bus.out_valid, 1'b0);
      chk("rst_uv", bus.unit_valid, 5'b0);
    end
    rst = 1'b1;
    tick;
    chk("post_rst_busy", bus.busy, 1'b0);
    chk("post_rst_ov", bus.out_valid, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_unit = EXEC_UNIT_ALU;
    #1;
    chk("s_uv", bus.unit_valid, 5'b00010);
    chk("s_ir", bus.in_ready, 1'b1);
    chk("s_data", bus.unit_data, 128'hDEAD_BEEF);
    tick;
    bus.in_valid = 1'b0;
    set_res(1, 96'h55);
    bus.out_ready = 1'b1;
    #1;
    chk("s_ov", bus.out_valid, 1'b1);
    chk("s_od", bus.out_data, 96'h55);
    chk("s_rr", bus.unit_res_ready, 5'b00010);
    chk("s_busy", bus.busy, 1'b1);
    tick;
    bus.unit_res_valid = '0;
    #1;
    chk("s_busy_fall", bus.busy, 1'b0);
    chk("s_ov_fall", bus.out_valid, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_unit = EXEC_UNIT_MEM;
    tick;
    bus.in_unit = EXEC_UNIT_ALU;
    tick;
    bus.in_valid = 1'b0;
    set_res(1, 96'hA1);
    #1;
    chk("ro_hold_ov", bus.out_valid, 1'b0);
    chk("ro_hold_rr", bus.unit_res_ready, 5'b00100);
    tick;
    chk("ro_hold_ov2", bus.out_valid, 1'b0);
    tick;
    set_res(2, 96'hB2);
    #1;
    chk("ro_mem_ov", bus.out_valid, 1'b1);
    chk("ro_mem_od", bus.out_data, 96'hB2);
    tick;
    bus.unit_res_valid[2] = 1'b0;
    #1;
    chk("ro_alu_ov", bus.out_valid, 1'b1);
    chk("ro_alu_od", bus.out_data, 96'hA1);
    chk("ro_alu_rr", bus.unit_res_ready, 5'b00010);
    tick;
    bus.unit_res_valid = '0;
    bus.out_ready = 1'b0;
    #1;
    chk("ro_busy", bus.busy, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_unit = EXEC_UNIT_PCREL;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("full_ir", bus.in_ready, 1'b1);
      tick;
    end
    chk("full_ir5", bus.in_ready, 1'b0);
    chk("full_uv5", bus.unit_valid, 5'b0);
    set_res(3, 96'h33);
    bus.out_ready = 1'b1;
    #1;
    chk("full_pop_ov", bus.out_valid, 1'b1);
    chk("full_same_ir", bus.in_ready, 1'b0);
    tick;
    bus.unit_res_valid = '0;
    bus.out_ready = 1'b0;
    #1;
    chk("full_next_ir", bus.in_ready, 1'b1);
    tick;
    bus.in_valid = 1'b0;
    set_res(3, 96'h34);
    bus.out_ready = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("full_drain_ov", bus.out_valid, 1'b1);
      tick;
    end
    bus.unit_res_valid = '0;
    #1;
    chk("full_busy", bus.busy, 1'b0);
    issued = 0;
    got = 0;
    for (int n = 0; n < 5; n++) begin
      ic[n] = 0;
      rc[n] = 0;
    end
    for (int c = 0; c < 400 && got < 20; c++) begin
      bus.in_valid = issued < 20;
      bus.in_unit = 3'(issued % 5);
      bus.out_ready = (c % 2) == 0;
      for (int n = 0; n < 5; n++) begin
        bus.unit_res_valid[n] = rc[n] < ic[n];
        bus.unit_res_data[n*96 +: 96] = {64'h0, 16'(n), 16'(rc[n])};
      end
      #1;
      if (bus.in_valid && bus.in_ready) begin
        chk("strm_uv", bus.unit_valid, 5'(1) << (issued % 5));
        ic[issued % 5]++;
        issued++;
      end
      if (bus.out_valid && bus.out_ready) begin
        chk("strm_od", bus.out_data, {64'h0, 16'(got % 5), 16'(got / 5)});
        got++;
      end
      for (int n = 0; n < 5; n++)
        if (bus.unit_res_ready[n] && bus.unit_res_valid[n]) rc[n]++;
      tick;
    end
    chk("strm_got", got, 20);
    chk("strm_issued", issued, 20);
    bus.in_valid = 1'b0;
    bus.unit_res_valid = '0;
    bus.out_ready = 1'b0;
    #1;
    chk("strm_busy", bus.busy, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_unit = 3'd7;
    #1;
    chk("ill_uv", bus.unit_valid, 5'b00001);
    chk("ill_ir", bus.in_ready, 1'b1);
    tick;
    bus.in_unit = EXEC_UNIT_ALU;
    tick;
    bus.in_unit = EXEC_UNIT_MEM;
    tick;
    bus.in_valid = 1'b0;
    set_res(0, 96'h0F);
    #1;
    chk("ar_busy_pre", bus.busy, 1'b1);
    chk("ar_ov_pre", bus.out_valid, 1'b1);
    rst = 1'b0;
    #1;
    chk("ar_busy", bus.busy, 1'b0);
    chk("ar_ov", bus.out_valid, 1'b0);
    tick;
    rst = 1'b1;
    bus.unit_res_valid = '0;
    tick;
    chk("ar_busy_rel", bus.busy, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/exec_dispatch.md
Name: exec_dispatch

Overview:
- Generalised issue/complete stage for the execute pipeline.
- Routes each decoded instruction to one of NUM_UNITS functional units, which may be multi-cycle and pipelined.
- Tracks outstanding instructions in an in-order unit-ID queue.
- Returns unit results in program order through a back-pressurable result port. The output is no longer assumed unblockable.

Parameters:
- NUM_UNITS, 5, number of functional units (misc, alu, mem, pcrel, csr); range 2..16.
- DATA_W, 128, width of the decoded instruction payload, broadcast to all units.
- RES_W, 96, width of one unit result.
- DEPTH, 4, maximum outstanding instructions; power of two, at least 2.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- in_valid  in  1  decoded instruction valid.
- in_ready  out  1  dispatcher accepts the instruction.
- in_unit  in  $clog2(NUM_UNITS)  target unit index, precomputed by decode from op/funct3.
- in_data  in  DATA_W  decoded instruction.
- unit_valid  out  NUM_UNITS  one-hot issue strobe.
- unit_ready  in  NUM_UNITS  per-unit accept.
- unit_data  out  DATA_W  broadcast copy of in_data.
- unit_res_valid  in  NUM_UNITS  per-unit result valid.
- unit_res_ready  out  NUM_UNITS  per-unit result consume.
- unit_res_data  in  NUM_UNITS*RES_W  packed results; unit i occupies [i*RES_W +: RES_W].
- out_valid  out  1  in-order result valid.
- out_ready  in  1  downstream accept.
- out_data  out  RES_W  in-order result.
- busy  out  1  queue non-empty.

Behaviour:
- Reset (rst low, asynchronous):
  - queue empty: head = tail = 0, count = 0.
  - unit_valid = 0, unit_res_ready = 0, out_valid = 0, busy = 0.
  - out_data is don't-care.
- Unit mapping: an in_unit value of NUM_UNITS or above is routed to unit 0 (the fallback unit that handles invalid instructions).
- Issue: when count < DEPTH, in_valid is high and unit_ready[u] is high, all of the following happen in the same cycle:
  - unit_valid[u] is high.
  - in_ready is high.
  - u is written at the tail, and tail and count are incremented.
- Issue blocking:
  - in_ready = (count < DEPTH) && unit_ready[u].
  - A full queue blocks issue even when a pop occurs in the same cycle. There is no out_ready→in_ready combinational path.
- unit_valid is combinational from in_valid, the count check and the decoded index. Only one bit is ever high.
- Completion: h is the unit ID at the head.
  - out_valid = !empty && unit_res_valid[h].
  - out_data = the slice for unit h.
  - unit_res_ready[h] = !empty && out_ready; all other bits are 0.
  - On out_valid && out_ready, head is incremented and count is decremented.
- Same-cycle path: when the queue is empty, out_valid is 0. A zero-latency unit therefore shows its result one cycle after issue at the earliest, giving a fixed minimum latency of 1.
- Results from non-head units are held by those units; the dispatcher does not consume them.
- Ordering: each unit completes in its own issue order. The dispatcher reorders across units to program order.
- Simultaneous push and pop: count is unchanged, and head and tail both advance.
- Wrap-around: head and tail are log2(DEPTH)-bit counters and wrap naturally. The full/empty decision uses count, which is $clog2(DEPTH)+1 bits.
- Reset mid-operation: all outstanding IDs are discarded. Units are reset on the same rst, so results in flight are lost.

Optional Feature:
- Macro EXEC_DISPATCH_OUT_REG_EN.
- When defined:
  - out_valid/out_data come from a 2-entry skid buffer.
  - Minimum latency becomes 2 cycles.
  - out_valid is a flop output, and unit_res_ready no longer depends combinationally on out_ready.
  - The buffer accepts while it has a free entry.
  - It is empty after reset.
- When undefined: the combinational output path described above applies.

Decomposition:
- Shared package (types package):
  - EXEC_UNIT_MISC=0, ALU=1, MEM=2, PCREL=3, CSR=4 unit-index constants.
  - exec_unit_t typedef.
  - Function unit_of(op, funct3) used by decode.
- Sub-module exec_id_fifo: parametrised DEPTH × width FIFO with push, pop, count, full and empty. It is reused for the ID queue and, with DEPTH=2, for the skid buffer.

Test Plan:
- Reset state: hold rst low and toggle clk → busy=0, out_valid=0, unit_valid=0. Check during reset and at the first cycle after release.
- Single issue: issue in_unit=1 (alu); unit 1 returns result 0x55 one cycle later → out_valid with out_data=0x55. unit_res_ready[1] is high in the same cycle. busy falls after the handshake.
- Cross-unit reorder: issue to mem (unit 2, 3-cycle latency), then alu (unit 1, 1-cycle latency). The alu result is held and out is not valid until the mem result arrives. Output order: mem result, then alu result.
- Full queue: DEPTH=4, units never respond, issue 5 instructions → the first 4 are accepted and in_ready stays low for the 5th. After one out handshake, the 5th is accepted the next cycle, not the same cycle.
- Back-pressure and wrap: with out_ready toggled 1/0 each cycle, stream 20 instructions round-robin across 5 units → all 20 results emerge in order with no loss or duplication. The tail pointer wraps 5 times.
- Illegal unit and async reset: in_unit=7 with NUM_UNITS=5 → unit_valid[0] is high. Assert rst mid-stream with 3 outstanding → busy and out_valid drop immediately, without waiting for a clock edge.
